agc_fetch: RTL and testbench

AGC_FETCH -- requirements
Module: agc_fetch

---
 rtl/agc_fetch.sv | 73 +++++++
 tb/tb_agc_fetch.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/agc_fetch.sv
// agc_fetch: AGC instruction fetch unit with one outstanding request, 2-entry prefetch FIFO and branch redirect.
// Defining AGC_FETCH_COUNT_EN adds fetch_count, a 16-bit count of decoder handshakes.
module agc_fetch (
    input  logic        clock,
    input  logic        rst,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [14:0] mem_rdata,
    input  logic        br_valid,
    input  logic [11:0] br_target,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_instr,
    output logic [11:0] out_pc
`ifdef AGC_FETCH_COUNT_EN
    ,
    output logic [15:0] fetch_count
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;
    state_t state;
    logic [11:0] pc, req_pc;
    logic [26:0] fifo [2];
    logic [1:0] count, fill;
    logic discard, pop, push, issue;
    assign out_valid = count != 2'd0;
    assign {out_instr, out_pc} = fifo[0];
    assign pop = out_valid && out_ready;
    assign fill = count - {1'b0, pop};
    // a request is only issued when its response is guaranteed a free slot
    assign issue = !rst && state == IDLE && !halt && !br_valid && fill < 2'd2;
    assign push = state == WAIT && mem_rvalid && !discard && !br_valid;
    assign mem_req = issue;
    assign mem_addr = pc;
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc <= 12'o4000;
            req_pc <= 12'o4000;
            count <= 2'd0;
            discard <= 1'b0;
            fifo[0] <= '0;
            fifo[1] <= '0;
        end else begin
            if (pop) fifo[0] <= fifo[1];
            if (push) fifo[fill[0]] <= {mem_rdata, req_pc};
            count <= br_valid ? 2'd0 : fill + {1'b0, push};
            pc <= br_valid ? br_target : issue ? pc + 12'd1 : pc;
            if (issue) req_pc <= pc;
            case (state)
                IDLE: state <= issue ? WAIT : halt ? HALTED : IDLE;
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= halt ? HALTED : IDLE;
                        discard <= 1'b0;
                    end else if (br_valid) begin
                        discard <= 1'b1;
                    end
                end
                HALTED: state <= halt ? HALTED : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef AGC_FETCH_COUNT_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst) fetch_count <= 16'd0;
        else if (pop) fetch_count <= fetch_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_agc_fetch.sv
// tb_agc_fetch: directed bench for agc_fetch, checked every cycle against a queue-based model.
module tb_agc_fetch;
    logic clock = 1'b0, rst = 1'b1;
    logic mem_req;
    logic [11:0] mem_addr;
    logic mem_rvalid = 1'b0;
    logic [14:0] mem_rdata = 15'd0;
    logic br_valid = 1'b0;
    logic [11:0] br_target = 12'd0;
    logic halt = 1'b0;
    logic out_valid, out_ready = 1'b1;
    logic [14:0] out_instr;
    logic [11:0] out_pc;
`ifdef AGC_FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif
    int compared = 0, mismatched = 0;
    logic [26:0] q [$];
    logic [11:0] m_pc = 12'o4000, m_addr = 12'd0;
    logic m_out = 1'b0, m_drop = 1'b0, m_halted = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    int lat = 1, mem_cnt = 0;
    logic mem_busy = 1'b0;
    logic [11:0] mem_a = 12'd0;
    logic [11:0] req_log [$], pop_log [$];

    always #5 clock = ~clock;

    agc_fetch dut (
        .clock(clock), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .br_valid(br_valid),
        .br_target(br_target), .halt(halt), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
`ifdef AGC_FETCH_COUNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    function automatic logic [14:0] word(input logic [11:0] a);
        return {a, 3'b101} ^ 15'h2a5c;
    endfunction

    function automatic logic [31:0] at(input logic [11:0] l [$], input int i);
        return (i >= 0 && i < l.size()) ? 32'(l[i]) : 32'hdead;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        logic s_rst, s_br, s_halt, s_ready, s_rv, s_req, e_req, pop;
        logic [11:0] s_tgt, s_addr;
        @(negedge clock);
        s_rst = rst; s_br = br_valid; s_tgt = br_target; s_halt = halt;
        s_ready = out_ready; s_rv = mem_rvalid; s_req = mem_req; s_addr = mem_addr;
        pop = !s_rst && q.size() > 0 && s_ready;
        e_req = !s_rst && !m_out && !m_halted && !s_halt && !s_br && (q.size() - (pop ? 1 : 0)) < 2;
        if (s_rst) begin
            chk("rst_out", {out_valid, out_pc, out_instr}, 32'd0);
            chk("rst_mem", {mem_req, mem_addr}, 32'o4000);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) chk("out_head", {out_instr, out_pc}, 32'(q[0]));
            chk("mem_req", 32'(s_req), 32'(e_req));
            if (e_req) chk("mem_addr", 32'(s_addr), 32'(m_pc));
        end
`ifdef AGC_FETCH_COUNT_EN
        chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
`endif
        if (s_req) req_log.push_back(s_addr);
        if (!s_rst && out_valid && s_ready) pop_log.push_back(out_pc);
        @(posedge clock);
        if (s_rst) begin
            q.delete(); m_pc = 12'o4000; m_out = 0; m_drop = 0; m_halted = 0; m_cnt = 0;
        end else begin
            if (pop) begin q.delete(0); m_cnt++; end
            if (m_out && s_rv) begin
                if (!m_drop && !s_br) q.push_back({word(m_addr), m_addr});
                m_out = 0; m_drop = 0;
            end else if (m_out && s_br) m_drop = 1;
            if (s_br) begin q.delete(); m_pc = s_tgt; end
            if (e_req) begin m_out = 1; m_addr = m_pc; m_pc++; end
            m_halted = s_halt && !m_out;
        end
        #1;
        if (mem_rvalid) mem_busy = 0;
        if (s_req) begin mem_busy = 1; mem_cnt = lat; mem_a = s_addr; end
        if (mem_busy) mem_cnt--;
        mem_rvalid = mem_busy && mem_cnt == 0;
        mem_rdata = mem_rvalid ? word(mem_a) : 15'd0;
    endtask

    task automatic wait_req(output logic [11:0] a);
        for (int i = 0; i < 20; i++) begin
            req_log.delete();
            cyc();
            if (req_log.size() > 0) begin a = req_log[0]; return; end
        end
        compared++; mismatched++;
        $display("FAIL wait_req: no mem_req within 20 cycles");
        a = 12'd0;
    endtask

    task automatic clr();
        req_log.delete(); pop_log.delete();
    endtask

    initial begin
        logic [11:0] a;
        repeat (3) cyc();
        rst = 0; clr(); repeat (8) cyc();
        chk("stream_req0", at(req_log, 0), 32'o4000);
        chk("stream_req1", at(req_log, 1), 32'o4001);
        chk("stream_req2", at(req_log, 2), 32'o4002);
        chk("stream_pop0", at(pop_log, 0), 32'o4000);
        chk("stream_pop1", at(pop_log, 1), 32'o4001);
        // mid-flight reset, then a stalled decoder fills the FIFO
        rst = 1; out_ready = 0; repeat (3) cyc();
        rst = 0; clr(); repeat (6) cyc();
        chk("stall_reqs", 32'(req_log.size()), 32'd2);
        chk("stall_pops", 32'(pop_log.size()), 32'd0);
        out_ready = 1; clr(); repeat (6) cyc();
        chk("drain_pop0", at(pop_log, 0), 32'o4000);
        chk("drain_pop1", at(pop_log, 1), 32'o4001);
        chk("drain_pop2", at(pop_log, 2), 32'o4002);
        lat = 3; wait_req(a);
        br_valid = 1; br_target = 12'o2100; cyc(); br_valid = 0;
        clr(); repeat (12) cyc();
        chk("br_wait_req", at(req_log, 0), 32'o2100);
        chk("br_wait_pop", at(pop_log, 0), 32'o2100);
        lat = 1; wait_req(a);
        br_valid = 1; br_target = 12'o1234; cyc(); br_valid = 0;
        clr(); repeat (4) cyc();
        chk("br_rv_req", at(req_log, 0), 32'o1234);
        chk("br_rv_pop", at(pop_log, 0), 32'o1234);
        halt = 1; br_valid = 1; br_target = 12'o0500; cyc(); br_valid = 0;
        clr(); repeat (5) cyc();
        chk("br_halt_noreq", 32'(req_log.size()), 32'd0);
        halt = 0; clr(); repeat (4) cyc();
        chk("br_halt_req", at(req_log, 0), 32'o0500);
        br_valid = 1; br_target = 12'o7777; cyc(); br_valid = 0;
        clr(); repeat (6) cyc();
        chk("wrap_req0", at(req_log, 0), 32'o7777);
        chk("wrap_req1", at(req_log, 1), 32'o0000);
        lat = 3; wait_req(a);
        halt = 1; clr(); repeat (8) cyc();
        chk("halt_noreq", 32'(req_log.size()), 32'd0);
        chk("halt_deliver", at(pop_log, pop_log.size() - 1), 32'(a));
        halt = 0; clr(); repeat (4) cyc();
        chk("halt_resume", at(req_log, 0), 32'(12'(a + 12'd1)));
        for (int i = 0; i < 150; i++) begin
            lat = 1 + i / 50;
            out_ready = (i % 3) != 0;
            halt = (i % 23) < 4;
            br_valid = (i % 37) == 5;
            br_target = 12'(i * 97);
            cyc();
        end
        br_valid = 0; halt = 0; out_ready = 1; repeat (8) cyc();
`ifdef AGC_FETCH_COUNT_EN
        lat = 1; rst = 1; repeat (3) cyc();
        rst = 0; clr();
        for (int i = 0; i < 80 && pop_log.size() < 10; i++) cyc();
        out_ready = 0; br_valid = 1; br_target = 12'o3000; cyc();
        br_valid = 0; out_ready = 1;
        for (int i = 0; i < 80 && pop_log.size() < 13; i++) cyc();
        out_ready = 0; cyc();
        chk("fetch_count_13", 32'(fetch_count), 32'd13);
        out_ready = 1; repeat (4) cyc();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
